// File: rtl/matrix_write_arbiter_pkg.sv
// Shared types and helpers for the matrix write arbiter: FSM state encoding,
// default matrix geometry and the row/column flattening used for the written bitmap.
package matrix_arb_pkg;

  localparam int DEF_SIZE_A = 32;
  localparam int DEF_SIZE_B = 32;
  localparam int TOTAL      = DEF_SIZE_A * DEF_SIZE_B;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    DRAIN,
    DONE
  } arb_state_t;

  // size_b lets a parameterised instance use its own column count.
  function automatic int unsigned flat_addr(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned size_b = DEF_SIZE_B);
    return row * size_b + col;
  endfunction

endpackage

// File: rtl/matrix_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester above last_grant wins,
// wrapping around; the grant is one-hot and its index is returned alongside.
module rr_arbiter #(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]         req,
  input  logic [$clog2(NUM_LANES)-1:0] last_grant,
  output logic [NUM_LANES-1:0]         grant,
  output logic [$clog2(NUM_LANES)-1:0] grant_idx
);

  localparam int IW = $clog2(NUM_LANES);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest overwrites.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = IW'((32'(last_grant) + 32'(k)) % NUM_LANES);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/matrix_write_arbiter.sv
// Shares the compiler's single element-write port between compute lanes (round robin),
// counts forwarded elements and sequences completion. Optional macro ARB_DUP_CHECK_EN adds a duplicate-address filter.
module matrix_write_arbiter
  import matrix_arb_pkg::*;
#(
  parameter int NUM_LANES        = 4,
  parameter int MAX_ELEMENT_SIZE = 8,
  parameter int MAX_SIZE_A       = 32,
  parameter int MAX_SIZE_B       = 32
) (
  input  logic                                      inter_refclk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [NUM_LANES-1:0]                      lane_valid,
  input  logic [NUM_LANES*$clog2(MAX_SIZE_A)-1:0]   lane_row,
  input  logic [NUM_LANES*$clog2(MAX_SIZE_B)-1:0]   lane_col,
  input  logic [NUM_LANES*MAX_ELEMENT_SIZE-1:0]     lane_element,
  output logic [NUM_LANES-1:0]                      lane_ready,
  input  logic                                      compile_done,
  output logic                                      wr_valid,
  output logic [$clog2(MAX_SIZE_A)-1:0]             wr_row_addr,
  output logic [$clog2(MAX_SIZE_B)-1:0]             wr_col_addr,
  output logic [MAX_ELEMENT_SIZE-1:0]               wr_element,
  output logic                                      busy,
  output logic                                      done,
  output logic [$clog2(MAX_SIZE_A*MAX_SIZE_B):0]    elem_count,
  output logic                                      dup_err
);

  localparam int RW = $clog2(MAX_SIZE_A);
  localparam int CW = $clog2(MAX_SIZE_B);
  localparam int EW = MAX_ELEMENT_SIZE;
  localparam int IW = $clog2(NUM_LANES);
  localparam int T  = MAX_SIZE_A * MAX_SIZE_B;
  localparam int NW = $clog2(T) + 1;

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        last_grant;
  logic [NUM_LANES-1:0] grant_p0;
  logic [IW-1:0]        grant_idx_p0;
  logic                 acc_p0, dup_p0, fwd_p0;
  logic [RW-1:0]        row_p0;
  logic [CW-1:0]        col_p0;
  logic [EW-1:0]        elem_p0;

  rr_arbiter #(.NUM_LANES(NUM_LANES)) u_rr (
    .req        (lane_valid),
    .last_grant (last_grant),
    .grant      (grant_p0),
    .grant_idx  (grant_idx_p0)
  );

  // Stage p0: arbitration and selection of the winning lane's fields
  assign lane_ready = (state == ARB) ? grant_p0 : '0;
  assign acc_p0     = (state == ARB) && (|grant_p0);
  assign row_p0     = lane_row[grant_idx_p0*RW +: RW];
  assign col_p0     = lane_col[grant_idx_p0*CW +: CW];
  assign elem_p0    = lane_element[grant_idx_p0*EW +: EW];
  assign fwd_p0     = acc_p0 && !dup_p0;

`ifdef ARB_DUP_CHECK_EN
  localparam int AW = $clog2(T);
  logic [T-1:0]  written;
  logic [AW-1:0] addr_p0;

  assign addr_p0 = AW'(flat_addr(32'(row_p0), 32'(col_p0), MAX_SIZE_B));
  assign dup_p0  = written[addr_p0];

  always_ff @(posedge inter_refclk or posedge rst) begin
    if (rst) begin
      written <= '0;
      dup_err <= 1'b0;
    end else if (state == IDLE && start) begin
      written <= '0;
      dup_err <= 1'b0;
    end else if (acc_p0) begin
      if (dup_p0) dup_err <= 1'b1;
      else        written[addr_p0] <= 1'b1;
    end
  end
`else
  assign dup_p0  = 1'b0;
  assign dup_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ARB;
      ARB:     if (fwd_p0 && elem_count == NW'(T - 1)) state_nxt = DRAIN;
      DRAIN:   if (compile_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge inter_refclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state == ARB) || (state == DRAIN);
  assign done = (state == DONE);

  // Stage p1: registered write port and element count
  always_ff @(posedge inter_refclk or posedge rst) begin
    if (rst) begin
      wr_valid    <= 1'b0;
      wr_row_addr <= '0;
      wr_col_addr <= '0;
      wr_element  <= '0;
      elem_count  <= '0;
      last_grant  <= IW'(NUM_LANES - 1);
    end else begin
      wr_valid <= fwd_p0;
      if (acc_p0) last_grant <= grant_idx_p0;
      if (fwd_p0) begin
        wr_row_addr <= row_p0;
        wr_col_addr <= col_p0;
        wr_element  <= elem_p0;
      end
      if (state == IDLE && start)
        elem_count <= '0;
      else if (fwd_p0 && elem_count != NW'(T))
        elem_count <= elem_count + 1'b1;
    end
  end

endmodule

// File: doc/matrix_write_arbiter.md
# matrix_write_arbiter

Round-robin arbiter and sequencer that shares the matrix compiler's single element-write port between `NUM_LANES` compute lanes. Each lane offers (row, col, element) results over valid/ready. The block grants one lane per cycle, registers the winner onto the write port and counts accepted elements. Once the full matrix has been issued, it stops granting, waits for the compiler's `compile_done` and pulses `done`. It lives entirely in the `inter_refclk` domain, between the compute lanes and the compiler.

## Interface
- `NUM_LANES`, 4, number of requesting lanes (2..8)
- `MAX_ELEMENT_SIZE`, 8, element width in bits
- `MAX_SIZE_A`, 32, matrix rows (power of 2)
- `MAX_SIZE_B`, 32, matrix columns (power of 2)
- `inter_refclk`  in  1  sole clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle pulse; begins a new matrix
- `lane_valid`  in  `NUM_LANES`  per-lane offer valid
- `lane_row`  in  `NUM_LANES` x `$clog2(MAX_SIZE_A)`  per-lane row address
- `lane_col`  in  `NUM_LANES` x `$clog2(MAX_SIZE_B)`  per-lane column address
- `lane_element`  in  `NUM_LANES` x `MAX_ELEMENT_SIZE`  per-lane data
- `lane_ready`  out  `NUM_LANES`  one-hot grant; a lane's offer is accepted when its `lane_valid` and `lane_ready` are both high
- `compile_done`  in  1  from the compiler: every element has been stored
- `wr_valid`  out  1  write strobe to the compiler (`valid_data_in`)
- `wr_row_addr`, `wr_col_addr`, `wr_element`  out  as the matching lane fields  registered write fields
- `busy`  out  1  high in the `ARB` and `DRAIN` states
- `done`  out  1  one-cycle completion pulse
- `elem_count`  out  `$clog2(MAX_SIZE_A*MAX_SIZE_B)+1`  number of elements forwarded
- `dup_err`  out  1  sticky duplicate flag (only with `ARB_DUP_CHECK_EN`)

## Operation
- FSM states: `IDLE`, `ARB`, `DRAIN`, `DONE`.
- `IDLE`
  - `lane_ready` = 0.
  - On `start`: clear `elem_count` and `dup_err`, go to `ARB`.
- `ARB`
  - `lane_ready` is combinational and one-hot: the first lane with `lane_valid` high, searching upward from `last_grant+1` with wrap-around.
  - On a grant: `last_grant` ← granted lane; the lane's fields are registered onto the `wr_*` outputs; `elem_count` increments.
  - When the accepted element brings `elem_count` to `TOTAL = MAX_SIZE_A*MAX_SIZE_B`, go to `DRAIN`.
- `DRAIN`
  - `lane_ready` = 0.
  - Wait for `compile_done`, then go to `DONE`.
- `DONE`
  - Pulse `done` for one cycle, then go to `IDLE`.
- `start` is ignored outside `IDLE`.
- `compile_done` is ignored outside `DRAIN`.
- `elem_count` saturates at `TOTAL`.
- `lane_ready` never depends on `lane_row`, `lane_col` or `lane_element`.

## Timing
- Reset values: all outputs 0; state `IDLE`; `last_grant` = `NUM_LANES-1`, so lane 0 wins first.
- Latency: an offer accepted in cycle N drives `wr_valid`=1 with its fields in cycle N+1. `wr_valid` stays high for exactly one cycle per accepted element.
- Throughput: one element per cycle in total across all lanes.
- Fairness: a lane that holds `lane_valid` high is granted within `NUM_LANES` cycles.
- The final accept and `busy`:
  - On the cycle the final element is accepted, the state moves to `DRAIN` at the next edge.
  - `busy` stays high through `DRAIN` and drops in `DONE`.
- `compile_done` and `done`:
  - `compile_done` arriving in the same cycle as the final `wr_valid` is honoured: `done` is asserted 2 cycles after the final accept.
  - Otherwise `done` is asserted the cycle after `compile_done` is seen in `DRAIN`.
- `rst` mid-operation: asynchronous clear to the reset values. Any in-flight `wr_valid` is dropped.

## Configuration
- `ARB_DUP_CHECK_EN` defined:
  - A `TOTAL`-bit written-bitmap is cleared on `start`.
  - An accepted element whose address bit is already set is still acked (`lane_ready`), but it is not forwarded and not counted, and it sets `dup_err`.
  - Same-cycle check: the bitmap is consulted for the address being granted in that cycle.
- `ARB_DUP_CHECK_EN` undefined:
  - No bitmap is built; every accepted element is forwarded and counted.
  - `dup_err` is tied to 0.

## Structure
- Package `matrix_arb_pkg`:
  - typedef `arb_state_t` (enum of the four states);
  - localparam `TOTAL`;
  - function `flat_addr(row, col)` returning `row*MAX_SIZE_B + col`.
- Sub-module `rr_arbiter`: inputs `req[NUM_LANES]` and `last_grant`; outputs one-hot `grant` and its encoded `grant_idx`. It is purely combinational; `last_grant` is registered in the parent.

## Test plan
- Single lane, 2x2 config (`MAX_SIZE_A`=`MAX_SIZE_B`=2): `start`, then lane 0 offers (0,0,0x11) (0,1,0x22) (1,0,0x33) (1,1,0x44) back to back → four `wr_valid` pulses, each one cycle after its accept, fields matching; `elem_count`=4; state `DRAIN`; `compile_done` → `done` pulse next cycle, `busy` low.
- 4 lanes all holding `lane_valid` high → grants rotate 0,1,2,3,0…, one per cycle; no lane starves.
- Lane 2 valid only on odd cycles, others always valid → lane 2 is granted within 4 cycles of each assertion.
- `rst` asserted mid-`ARB` after 3 accepts → all outputs 0 immediately; `elem_count`=0; `start` restarts from lane 0.
- With `ARB_DUP_CHECK_EN`: address (1,1) offered twice → second offer acked; no `wr_valid` for it; `dup_err`=1; `elem_count` unchanged.
- `compile_done` coincident with the final `wr_valid` → `done` asserted exactly 2 cycles after the final accept; `start` pulsed during `DRAIN` → no effect.
